mem_resp_sram: RTL and testbench
================================

Name: mem_resp_sram

Overview:
- Slave-side responder for the core's generic memory request/grant/rvalid protocol.
- Accepts requests from a master (address, wdata, req, we, be) and returns grant, in-order rvalid and rdata.
- Backed by a byte-enabled word array, with configurable grant delay, response latency and outstanding limit.
- Used as the memory model in unit benches and as a scratchpad behind the core's memory port.

Parameters:
- ADDRESS_SIZE, 64, width of address.
- DATA_WIDTH, 64, width of rdata/wdata; must be a power of two, >= 8.
- DEPTH, 1024, number of DATA_WIDTH words; power of two.
- LATENCY, 1, cycles from grant to rvalid; >= 1.
- GNT_DELAY, 0, cycles req must be held before gnt asserts; 0 = same-cycle grant.
- MAX_OUTSTANDING, 2, maximum granted-but-not-responded requests; >= 1.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- address_i  input  ADDRESS_SIZE  byte address of request.
- data_wdata_i  input  DATA_WIDTH  write data.
- data_req_i  input  1  request valid; held with all request fields until granted.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  DATA_WIDTH/8  byte enables for writes; ignored for reads.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid, one cycle per granted request.
- data_rdata_o  output  DATA_WIDTH  read data; 0 for write responses.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: data_gnt_o=0 (combinational, forced 0 while rst_i high), data_rvalid_o=0, data_rdata_o=0, wait counter=0, outstanding=0, response pipeline emptied.
  - Memory array is not reset.
  - Reset mid-operation discards all in-flight responses; no rvalid follows for them.
- Addressing:
  - Word index = address_i[log2(DATA_WIDTH/8) +: log2(DEPTH)].
  - Upper address bits and low byte-offset bits are ignored, so out-of-range addresses alias modulo DEPTH.
- Grant wait counter (wait_cnt, 0..GNT_DELAY):
  - Increments each cycle req is high and wait_cnt<GNT_DELAY.
  - Clears to 0 on grant or when req is low.
- Outstanding counter:
  - next = outstanding + gnt - rvalid.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Grant condition: data_gnt_o = data_req_i && wait_cnt==GNT_DELAY && (outstanding - data_rvalid_o) < MAX_OUTSTANDING.
  - Combinational; a slot freed by an rvalid in the same cycle may be reused in that cycle.
- Grant cycle t:
  - Write: bytes with data_be_i[i]=1 are written at the end of t; other bytes are unchanged. be=0 writes nothing but still responds.
  - Read: the word is sampled at t from the array contents before any write at the end of t. Only one request per cycle, so there is no conflict.
  - A read granted at t+1 to the same word sees data written at t.
- Response:
  - Shift pipeline of LATENCY stages carrying {valid, rdata}.
  - data_rvalid_o=1 exactly in cycle t+LATENCY for a grant at t, with data_rdata_o registered.
  - Responses are strictly in grant order.
  - No backpressure: the master must accept every rvalid.
  - data_rdata_o=0 whenever data_rvalid_o=0 or the response is for a write.
- Back-to-back throughput:
  - GNT_DELAY=0 with MAX_OUTSTANDING>=LATENCY gives one grant per cycle.
  - Otherwise throughput is limited by either constraint.
- Protocol violation:
  - req dropped before grant: wait_cnt clears and no transaction occurs.
  - Address or we changed while waiting: the values at the grant cycle are used.

Test Plan:
- Reset, LATENCY=1, GNT_DELAY=0:
  - write addr 0x10, wdata 0xDEADBEEF_CAFEF00D, be 0xFF → gnt same cycle, rvalid next cycle with rdata 0.
  - Then read 0x10 → rvalid 1 cycle after gnt with rdata 0xDEADBEEF_CAFEF00D.
- Partial write: after the above, write 0x10, wdata 0x11223344_55667788, be 0x0F → read 0x10 returns 0xDEADBEEF_55667788.
- GNT_DELAY=3, req held continuously:
  - gnt asserts on the 4th cycle of req; wait_cnt restarts for the next request.
  - req pulsed for 2 cycles then dropped → no gnt, no rvalid.
- LATENCY=4, MAX_OUTSTANDING=2, 5 back-to-back reads of addresses 0..4 (preloaded with value = index):
  - gnts at cycles 0,1,4,5,8.
  - rvalids at 4,5,8,9,12 with rdata 0,1,2,3,4 in order.
- Aliasing with DEPTH=1024, DATA_WIDTH=64: write 0x2008 with 0xA5 → read 0x0008 returns 0xA5.
- Reset asserted asynchronously with 2 reads in flight (LATENCY=3):
  - outputs go to 0 immediately, no rvalid afterwards.
  - After deassert, a new read is granted and answered normally.

Source files
------------

// File: rtl/mem_resp_sram.sv
// mem_resp_sram: slave responder for the req/gnt/rvalid memory protocol.
// Byte-enabled word array with grant delay, response pipeline and outstanding cap.
module mem_resp_sram #(
   parameter int ADDRESS_SIZE    = 64,
   parameter int DATA_WIDTH      = 64,
   parameter int DEPTH           = 1024,
   parameter int LATENCY         = 1,
   parameter int GNT_DELAY       = 0,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDRESS_SIZE-1:0] address_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   input  logic                    data_req_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WC_W  = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
   localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [WC_W-1:0] WC_MAX = WC_W'(GNT_DELAY);
   localparam logic [OS_W-1:0] OS_MAX = OS_W'(MAX_OUTSTANDING);

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
   } resp_t;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0] idx;
   logic [WC_W-1:0]  wait_q;
   logic [WC_W-1:0]  wait_d;
   logic [OS_W-1:0]  out_q;
   logic [OS_W-1:0]  out_d;
   logic [OS_W-1:0]  out_busy;
   resp_t            pipe_q [LATENCY];
   resp_t            resp_in;
   resp_t            head;
   logic             gnt;
   logic             addr_unused;

   // Upper and byte-offset bits are dropped, so addresses alias modulo DEPTH.
   assign idx         = address_i[OFF_W +: IDX_W];
   assign addr_unused = ^address_i;

   assign head          = pipe_q[LATENCY-1];
   assign data_rvalid_o = head.valid;
   assign data_rdata_o  = head.data;
   assign data_gnt_o    = gnt;

   // A slot retiring this cycle can be handed to a new request in the same cycle.
   always_comb begin
      out_busy = out_q - OS_W'(head.valid);
      gnt      = !rst_i && data_req_i &&
                 (wait_q == WC_MAX) && (out_busy < OS_MAX);
      wait_d = wait_q;
      if (!data_req_i || gnt) begin
         wait_d = '0;
      end else if (wait_q != WC_MAX) begin
         wait_d = wait_q + 1'b1;
      end
      out_d = out_q + OS_W'(gnt) - OS_W'(head.valid);
   end

   always_comb begin
      resp_in       = '0;
      resp_in.valid = gnt;
      if (gnt && !data_we_i) begin
         resp_in.data = mem_q[idx];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q <= '0;
         out_q  <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         wait_q    <= wait_d;
         out_q     <= out_d;
         pipe_q[0] <= resp_in;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   // Array contents survive reset; reads above see the pre-write word.
   always_ff @(posedge clk_i) begin
      if (gnt && data_we_i) begin
         for (int b = 0; b < BYTES; b++) begin
            if (data_be_i[b]) begin
               mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_resp_sram.sv
// tb_mem_resp_sram: four responder configurations under directed and random
// traffic, compared every cycle against a transaction-level model.
module tb_mem_resp_sram;

   localparam int N = 4;
   localparam int LAT_T [N] = '{1, 2, 4, 3};
   localparam int GD_T  [N] = '{0, 3, 0, 0};
   localparam int MO_T  [N] = '{2, 1, 2, 2};

   logic        clk = 1'b0;
   logic        rst    [N];
   logic [63:0] addr   [N];
   logic [63:0] wd     [N];
   logic        req    [N];
   logic        we     [N];
   logic [7:0]  be     [N];
   logic        gnt    [N];
   logic        rvalid [N];
   logic [63:0] rdata  [N];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [63:0] mmem  [N][1024];
   logic [7:0]  kn    [N][1024];
   logic        ev    [N][16];
   logic [63:0] ed    [N][16];
   logic [63:0] em    [N][16];
   int          out_m [N];
   int          held  [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_resp_sram #(
         .ADDRESS_SIZE   (64),
         .DATA_WIDTH     (64),
         .DEPTH          (1024),
         .LATENCY        (LAT_T[g]),
         .GNT_DELAY      (GD_T[g]),
         .MAX_OUTSTANDING(MO_T[g])
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst[g]),
         .address_i    (addr[g]),
         .data_wdata_i (wd[g]),
         .data_req_i   (req[g]),
         .data_we_i    (we[g]),
         .data_be_i    (be[g]),
         .data_gnt_o   (gnt[g]),
         .data_rvalid_o(rvalid[g]),
         .data_rdata_o (rdata[g])
      );
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] b);
      req[k]  = 1'b1;
      we[k]   = w;
      addr[k] = a;
      wd[k]   = d;
      be[k]   = b;
   endtask

   task automatic idle(input int k);
      req[k]  = 1'b0;
      we[k]   = 1'b0;
      addr[k] = '0;
      wd[k]   = '0;
      be[k]   = '0;
   endtask

   task automatic rnd_req(input int k);
      logic [63:0] a;
      a       = {$urandom, $urandom};
      a[12:3] = 10'($urandom_range(0, 31));
      drive(k, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom));
   endtask

   // Starts and ends at posedge+1.
   task automatic xfer(input int k, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] b,
                       output int waits, output int lat,
                       output logic [63:0] rd);
      drive(k, w, a, d, b);
      waits = 0;
      @(negedge clk);
      while (!gnt[k] && waits < 40) begin
         waits++;
         step();
         @(negedge clk);
      end
      if (!gnt[k]) chk($sformatf("gnt_timeout%0d", k), 64'(gnt[k]), 64'd1);
      step();
      idle(k);
      lat = 1;
      @(negedge clk);
      while (!rvalid[k] && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      if (!rvalid[k]) chk($sformatf("rv_timeout%0d", k), 64'(rvalid[k]), 64'd1);
      rd = rdata[k];
      step();
   endtask

   // Model: expected responses held in slots keyed by due cycle.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            int s, ds, ix;
            logic er, eg;
            logic [63:0] xd, xm;
            s = cyc % 16;
            if (rst[k]) begin
               chk($sformatf("rst_gnt%0d", k), 64'(gnt[k]), 64'd0);
               chk($sformatf("rst_rv%0d", k), 64'(rvalid[k]), 64'd0);
               chk($sformatf("rst_rd%0d", k), rdata[k], 64'd0);
               for (int j = 0; j < 16; j++) ev[k][j] = 1'b0;
               out_m[k] = 0;
               held[k]  = 0;
            end else begin
               er = ev[k][s];
               eg = req[k] && (held[k] >= GD_T[k]) &&
                    ((out_m[k] - int'(er)) < MO_T[k]);
               xd = er ? ed[k][s] : 64'd0;
               xm = er ? em[k][s] : '1;
               chk($sformatf("gnt%0d", k), 64'(gnt[k]), 64'(eg));
               chk($sformatf("rvalid%0d", k), 64'(rvalid[k]), 64'(er));
               chk($sformatf("rdata%0d", k), rdata[k] & xm, xd & xm);
               if (er) begin
                  ev[k][s] = 1'b0;
                  out_m[k]--;
               end
               if (eg) begin
                  ix = int'(addr[k][12:3]);
                  ds = (cyc + LAT_T[k]) % 16;
                  ev[k][ds] = 1'b1;
                  out_m[k]++;
                  if (we[k]) begin
                     ed[k][ds] = '0;
                     em[k][ds] = '1;
                     for (int b = 0; b < 8; b++) begin
                        if (be[k][b]) begin
                           mmem[k][ix][8*b +: 8] = wd[k][8*b +: 8];
                           kn[k][ix][b] = 1'b1;
                        end
                     end
                  end else begin
                     ed[k][ds] = mmem[k][ix];
                     for (int b = 0; b < 8; b++)
                        em[k][ds][8*b +: 8] = {8{kn[k][ix][b]}};
                  end
               end
               held[k] = (req[k] && !eg) ? held[k] + 1 : 0;
            end
         end
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w, l, cnt, g, r;
      logic [63:0] rd;
      int gc [5];
      int rc [5];
      logic [63:0] rdd [5];
      int gexp [5];
      int rexp [5];
      logic gp [N];

      for (int k = 0; k < N; k++) begin
         rst[k]   = 1'b1;
         idle(k);
         out_m[k] = 0;
         held[k]  = 0;
         gp[k]    = 1'b0;
         for (int j = 0; j < 16; j++) ev[k][j] = 1'b0;
         for (int i = 0; i < 1024; i++) kn[k][i] = '0;
      end
      req[0]  = 1'b1;
      addr[0] = 64'h10;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_gnt", 64'(gnt[0]), 64'd0);
      chk("reset_rvalid", 64'(rvalid[0]), 64'd0);
      chk("reset_rdata", rdata[0], 64'd0);
      step();
      for (int k = 0; k < N; k++) rst[k] = 1'b0;
      idle(0);
      step();

      xfer(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, w, l, rd);
      chk("wr_wait", 64'(w), 64'd0);
      chk("wr_lat", 64'(l), 64'd1);
      chk("wr_rdata", rd, 64'd0);
      xfer(0, 1'b0, 64'h10, 64'd0, 8'h00, w, l, rd);
      chk("rd_wait", 64'(w), 64'd0);
      chk("rd_lat", 64'(l), 64'd1);
      chk("rd_data", rd, 64'hDEADBEEF_CAFEF00D);
      xfer(0, 1'b1, 64'h10, 64'h11223344_55667788, 8'h0F, w, l, rd);
      xfer(0, 1'b0, 64'h10, 64'd0, 8'h00, w, l, rd);
      chk("part_data", rd, 64'hDEADBEEF_55667788);
      xfer(0, 1'b1, 64'h2008, 64'hA5, 8'hFF, w, l, rd);
      xfer(0, 1'b0, 64'h0008, 64'd0, 8'h00, w, l, rd);
      chk("alias_data", rd, 64'hA5);

      drive(1, 1'b1, 64'h40, 64'h1, 8'hFF);
      cnt = 0;
      @(negedge clk);
      while (!gnt[1] && cnt < 20) begin
         cnt++;
         step();
         @(negedge clk);
      end
      chk("gd_first", 64'(cnt), 64'd3);
      step();
      drive(1, 1'b1, 64'h48, 64'h2, 8'hFF);
      cnt = 0;
      @(negedge clk);
      while (!gnt[1] && cnt < 20) begin
         cnt++;
         step();
         @(negedge clk);
      end
      chk("gd_second", 64'(cnt), 64'd3);
      step();
      idle(1);
      repeat (4) step();
      drive(1, 1'b0, 64'h40, 64'd0, 8'h00);
      cnt = 0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         cnt += int'(gnt[1]);
         step();
      end
      idle(1);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         cnt += int'(gnt[1]) + int'(rvalid[1]);
         step();
      end
      chk("pulse_quiet", 64'(cnt), 64'd0);

      for (int i = 0; i < 5; i++)
         xfer(2, 1'b1, 64'(i * 8), 64'(i), 8'hFF, w, l, rd);
      gexp = '{0, 1, 4, 5, 8};
      rexp = '{4, 5, 8, 9, 12};
      for (int i = 0; i < 5; i++) begin
         gc[i]  = -1;
         rc[i]  = -1;
         rdd[i] = '1;
      end
      g = 0;
      r = 0;
      drive(2, 1'b0, 64'h0, 64'd0, 8'h00);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rvalid[2] && r < 5) begin
            rc[r]  = n;
            rdd[r] = rdata[2];
            r++;
         end
         if (gnt[2] && g < 5) begin
            gc[g] = n;
            g++;
         end
         step();
         if (g == 5) idle(2);
         else addr[2] = 64'(g * 8);
      end
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("burst_gnt%0d", i), 64'(gc[i]), 64'(gexp[i]));
         chk($sformatf("burst_rv%0d", i), 64'(rc[i]), 64'(rexp[i]));
         chk($sformatf("burst_rd%0d", i), rdd[i], 64'(i));
      end

      xfer(3, 1'b1, 64'h0, 64'h1111, 8'hFF, w, l, rd);
      xfer(3, 1'b1, 64'h8, 64'h2222, 8'hFF, w, l, rd);
      drive(3, 1'b0, 64'h0, 64'd0, 8'h00);
      @(negedge clk);
      chk("rs_gnt0", 64'(gnt[3]), 64'd1);
      step();
      addr[3] = 64'h8;
      @(negedge clk);
      chk("rs_gnt1", 64'(gnt[3]), 64'd1);
      step();
      idle(3);
      @(negedge clk);
      step();
      @(negedge clk);
      chk("rs_pre_rv", 64'(rvalid[3]), 64'd1);
      chk("rs_pre_rd", rdata[3], 64'h1111);
      #2;
      rst[3] = 1'b1;
      #1;
      chk("rs_async_rv", 64'(rvalid[3]), 64'd0);
      chk("rs_async_rd", rdata[3], 64'd0);
      step();
      step();
      rst[3] = 1'b0;
      cnt = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         cnt += int'(rvalid[3]);
         step();
      end
      chk("rs_quiet", 64'(cnt), 64'd0);
      xfer(3, 1'b0, 64'h8, 64'd0, 8'h00, w, l, rd);
      chk("rs_after_lat", 64'(l), 64'd3);
      chk("rs_after_rd", rd, 64'h2222);

      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) gp[k] = gnt[k];
         step();
         for (int k = 0; k < N; k++) begin
            if (req[k] && !gp[k]) begin
               r = int'($urandom_range(0, 99));
               if (r < 4) idle(k);
               else if (r < 8) rnd_req(k);
            end else if ($urandom_range(0, 99) < 60) begin
               rnd_req(k);
            end else begin
               idle(k);
            end
         end
      end
      for (int k = 0; k < N; k++) idle(k);
      repeat (10) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
